// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32-entry register bank write side.
package regfile_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned SEL_W    = $clog2(NUM_REGS);

    typedef enum logic {
        IDLE,
        CLEAR
    } wp_state_e;

endpackage

// File: rtl/regfile_write_port_if.sv
// Write-request handshake bundle: selector, data and byte strobes over valid/ready.
interface regfile_write_port_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) ();

    logic                 wr_valid;
    logic                 wr_ready;
    logic [SEL_W-1:0]     wr_sel;
    logic [WIDTH-1:0]     wr_data;
    logic [WIDTH/8-1:0]   wr_strb;

    modport master (
        output wr_valid,
        output wr_sel,
        output wr_data,
        output wr_strb,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_sel,
        input  wr_data,
        input  wr_strb,
        output wr_ready
    );

endinterface

// File: rtl/regfile_write_port_decoder_5to32.sv
// Selector to one-hot entry enable; the structural dual of the 32:1 read mux.
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic [SEL_W-1:0]    sel_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    // One bit set at the selected index when enabled, all zero otherwise.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32-entry register bank: one-deep write stage, byte-lane
// commit into storage, and a 32-cycle sequential clear.
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter bit          ZERO_REG0 = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_write_port_if.slave  wr,
    input  logic                 clr_req,
    output logic                 clr_busy,
    output logic                 commit_valid,
    output logic [SEL_W-1:0]     commit_sel,
    output logic [WIDTH-1:0]     regs [NUM_REGS]
);

    localparam int unsigned LANES = WIDTH / 8;

    wp_state_e            state_q, state_d;
    logic [SEL_W-1:0]     idx_q, idx_d;

    logic                 stage_valid_q, stage_valid_d;
    logic [SEL_W-1:0]     stage_sel_q, stage_sel_d;
    logic [WIDTH-1:0]     stage_data_q, stage_data_d;
    logic [LANES-1:0]     stage_strb_q, stage_strb_d;

    logic                 commit_valid_q;
    logic [SEL_W-1:0]     commit_sel_q;

    logic [WIDTH-1:0]     regs_q [NUM_REGS];
    logic [WIDTH-1:0]     regs_d [NUM_REGS];

    logic [NUM_REGS-1:0]  onehot;
    logic                 accept;

    assign wr.wr_ready  = (state_q == IDLE);
    assign accept       = wr.wr_valid && wr.wr_ready;
    assign clr_busy     = (state_q == CLEAR);
    assign commit_valid = commit_valid_q;
    assign commit_sel   = commit_sel_q;
    assign regs         = regs_q;

    decoder_5to32 u_dec (
        .sel_i    (stage_sel_q),
        .en_i     (stage_valid_q),
        .onehot_o (onehot)
    );

    // Next state and clear index: IDLE enters CLEAR on clr_req; CLEAR walks 0..31.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == SEL_W'(NUM_REGS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage capture: loads on accept, always drains the following edge.
    always_comb begin
        stage_valid_d = accept;
        stage_sel_d   = stage_sel_q;
        stage_data_d  = stage_data_q;
        stage_strb_d  = stage_strb_q;
        if (accept) begin
            stage_sel_d  = wr.wr_sel;
            stage_data_d = wr.wr_data;
            stage_strb_d = wr.wr_strb;
        end
    end

    // Storage next state: strobed lanes of the selected entry take the staged
    // data; the clear of the current index is applied afterwards so it wins.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned e = 0; e < NUM_REGS; e++) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (onehot[e] && stage_strb_q[b]) begin
                    regs_d[e][8*b +: 8] = stage_data_q[8*b +: 8];
                end
            end
            if ((state_q == CLEAR) && (idx_q == SEL_W'(e))) begin
                regs_d[e] = '0;
            end
        end
        if (ZERO_REG0) begin
            regs_d[0] = '0;
        end
    end

    // Control state, stage and commit report registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            stage_valid_q  <= 1'b0;
            stage_sel_q    <= '0;
            stage_data_q   <= '0;
            stage_strb_q   <= '0;
            commit_valid_q <= 1'b0;
            commit_sel_q   <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            stage_valid_q  <= stage_valid_d;
            stage_sel_q    <= stage_sel_d;
            stage_data_q   <= stage_data_d;
            stage_strb_q   <= stage_strb_d;
            commit_valid_q <= stage_valid_q;
            commit_sel_q   <= stage_sel_q;
        end
    end

    // Register array storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned e = 0; e < NUM_REGS; e++) begin
                regs_q[e] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule
